// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: frames host commands with CRC7, hands them to the PHY and
// validates responses with timeout/CRC retry. Define SD_CMD_RSP_CRC_EN to check response CRC7.
module sd_cmd_engine #(
  parameter int TO_W    = 32,
  parameter int RETRY_W = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               new_command,
  input  logic [5:0]         cmd_index,
  input  logic [31:0]        cmd_argument,
  input  logic [1:0]         rsp_type,
  input  logic [TO_W-1:0]    timeout_limit,
  input  logic [RETRY_W-1:0] max_retries,
  output logic               busy,
  output logic               command_complete,
  output logic               command_timeout,
  output logic               command_index_error,
  output logic               crc_error,
  output logic [127:0]       response,
  output logic [47:0]        tx_frame,
  output logic               tx_strobe,
  input  logic               tx_done,
  input  logic               rx_strobe,
  input  logic [135:0]       rx_frame,
  output logic               rx_ack
);
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT_RSP = 2'd2} state_t;

  localparam logic [1:0] RSP_NONE  = 2'b00;
  localparam logic [1:0] RSP_SHORT = 2'b01;
  localparam logic [1:0] RSP_LONG  = 2'b10;

  state_t             state, state_next;
  logic [1:0]         rsp_type_q, rsp_type_next;
  logic [TO_W-1:0]    limit_q, limit_next;
  logic [TO_W-1:0]    count, count_next;
  logic [RETRY_W-1:0] max_retries_q, max_retries_next;
  logic [RETRY_W-1:0] retry_cnt, retry_cnt_next;
  logic               busy_next, tx_strobe_next, rx_ack_next;
  logic               complete_next, timeout_next, index_error_next;
  logic [127:0]       response_next;
  logic [47:0]        tx_frame_next;
  logic               index_ok;
  logic               unused_rx;

  // MSB-first CRC7 (x^7+x^3+1, init 0); leading zeros leave it unchanged,
  // so shorter messages are zero-extended to 120 bits.
  function automatic logic [6:0] crc7(input logic [119:0] bits);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      fb = bits[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [47:0] build_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] head;
    head = {2'b01, idx, arg};
    return {head, crc7({80'b0, head}), 1'b1};
  endfunction

  // The latched command index lives in the held frame.
  always_comb begin
    case (rsp_type_q)
      RSP_SHORT: index_ok = (rx_frame[45:40] == tx_frame[45:40]);
      RSP_LONG:  index_ok = (rx_frame[133:128] == 6'h3F);
      default:   index_ok = 1'b1;
    endcase
  end

`ifdef SD_CMD_RSP_CRC_EN
  logic crc_ok;
  logic crc_error_next;

  always_comb begin
    case (rsp_type_q)
      RSP_SHORT: crc_ok = (crc7({80'b0, rx_frame[47:8]}) == rx_frame[7:1]);
      RSP_LONG:  crc_ok = (crc7(rx_frame[127:8]) == rx_frame[7:1]);
      default:   crc_ok = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) crc_error <= 1'b0;
    else       crc_error <= crc_error_next;
  end
`else
  assign crc_error = 1'b0;
`endif

  assign unused_rx = ^{rx_frame[135:134], rx_frame[47:46], rx_frame[7:0]};

  always_comb begin
    state_next       = state;
    rsp_type_next    = rsp_type_q;
    limit_next       = limit_q;
    max_retries_next = max_retries_q;
    count_next       = count;
    retry_cnt_next   = retry_cnt;
    response_next    = response;
    tx_frame_next    = tx_frame;
    complete_next    = 1'b0;
    timeout_next     = 1'b0;
    index_error_next = 1'b0;
    rx_ack_next      = 1'b0;
`ifdef SD_CMD_RSP_CRC_EN
    crc_error_next   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (new_command) begin
          rsp_type_next    = rsp_type;
          limit_next       = timeout_limit;
          max_retries_next = max_retries;
          retry_cnt_next   = '0;
          tx_frame_next    = build_frame(cmd_index, cmd_argument);
          state_next       = SEND;
        end
      end
      SEND: begin
        if (tx_done) begin
          count_next = '0;
          if (rsp_type_q == RSP_NONE) begin
            complete_next = 1'b1;
            state_next    = IDLE;
          end else begin
            state_next = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        // A response arriving on the limit cycle takes priority over the timeout.
        if (rx_strobe) begin
          rx_ack_next = 1'b1;
          state_next  = IDLE;
          if (!index_ok) begin
            index_error_next = 1'b1;
`ifdef SD_CMD_RSP_CRC_EN
          end else if (!crc_ok) begin
            if (retry_cnt < max_retries_q) begin
              retry_cnt_next = retry_cnt + 1'b1;
              state_next     = SEND;
            end else begin
              crc_error_next = 1'b1;
            end
`endif
          end else begin
            complete_next = 1'b1;
            response_next = (rsp_type_q == RSP_LONG) ? rx_frame[127:0] : {96'b0, rx_frame[39:8]};
          end
        end else if (count == limit_q) begin
          if (retry_cnt < max_retries_q) begin
            retry_cnt_next = retry_cnt + 1'b1;
            state_next     = SEND;
          end else begin
            timeout_next = 1'b1;
            state_next   = IDLE;
          end
        end else begin
          count_next = count + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next      = (state_next != IDLE);
    tx_strobe_next = (state_next == SEND);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      rsp_type_q          <= '0;
      limit_q             <= '0;
      max_retries_q       <= '0;
      count               <= '0;
      retry_cnt           <= '0;
      response            <= '0;
      tx_frame            <= '0;
      busy                <= 1'b0;
      tx_strobe           <= 1'b0;
      rx_ack              <= 1'b0;
      command_complete    <= 1'b0;
      command_timeout     <= 1'b0;
      command_index_error <= 1'b0;
    end else begin
      state               <= state_next;
      rsp_type_q          <= rsp_type_next;
      limit_q             <= limit_next;
      max_retries_q       <= max_retries_next;
      count               <= count_next;
      retry_cnt           <= retry_cnt_next;
      response            <= response_next;
      tx_frame            <= tx_frame_next;
      busy                <= busy_next;
      tx_strobe           <= tx_strobe_next;
      rx_ack              <= rx_ack_next;
      command_complete    <= complete_next;
      command_timeout     <= timeout_next;
      command_index_error <= index_error_next;
    end
  end
endmodule

// File: tb/tb_sd_cmd_engine.sv
// Bench for sd_cmd_engine: table of known SD frames, directed retry/timeout/reset
// sequences and randomized transactions against a transaction-level model.
module tb_sd_cmd_engine;
  localparam int TO_W    = 32;
  localparam int RETRY_W = 2;
`ifdef SD_CMD_RSP_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  // Control vector: {busy, tx_strobe, rx_ack, complete, timeout, index_error, crc_error}
  localparam logic [6:0] C_IDLE      = 7'b0000000;
  localparam logic [6:0] C_SEND      = 7'b1100000;
  localparam logic [6:0] C_WAIT      = 7'b1000000;
  localparam logic [6:0] C_DONE_NONE = 7'b0001000;
  localparam logic [6:0] C_RSP_OK    = 7'b0011000;
  localparam logic [6:0] C_IDXERR    = 7'b0010010;
  localparam logic [6:0] C_CRC_RETRY = 7'b1110000;
  localparam logic [6:0] C_CRC_FAIL  = 7'b0010001;
  localparam logic [6:0] C_TIMEOUT   = 7'b0000100;

  logic               clock = 1'b0;
  logic               reset;
  logic               new_command;
  logic [5:0]         cmd_index;
  logic [31:0]        cmd_argument;
  logic [1:0]         rsp_type;
  logic [TO_W-1:0]    timeout_limit;
  logic [RETRY_W-1:0] max_retries;
  logic               busy, command_complete, command_timeout, command_index_error, crc_error;
  logic [127:0]       response;
  logic [47:0]        tx_frame;
  logic               tx_strobe, tx_done, rx_strobe, rx_ack;
  logic [135:0]       rx_frame;

  always #5 clock = ~clock;

  sd_cmd_engine #(.TO_W(TO_W), .RETRY_W(RETRY_W)) dut (
    .clock(clock), .reset(reset), .new_command(new_command), .cmd_index(cmd_index),
    .cmd_argument(cmd_argument), .rsp_type(rsp_type), .timeout_limit(timeout_limit),
    .max_retries(max_retries), .busy(busy), .command_complete(command_complete),
    .command_timeout(command_timeout), .command_index_error(command_index_error),
    .crc_error(crc_error), .response(response), .tx_frame(tx_frame), .tx_strobe(tx_strobe),
    .tx_done(tx_done), .rx_strobe(rx_strobe), .rx_frame(rx_frame), .rx_ack(rx_ack)
  );

  typedef struct {
    int unsigned  hold;
    int unsigned  delay;
    logic [5:0]   idx_xor;
    logic [6:0]   crc_xor;
    logic [127:0] data;
  } attempt_t;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [47:0] frame;
  } tbl_t;

  int           checks = 0;
  int           errors = 0;
  logic [127:0] resp_model;
  attempt_t     plan [4];
  tbl_t         tbl [5];

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] ref_crc(input logic [119:0] msg);
    logic [126:0] r;
    r = {msg, 7'b0};
    for (int i = 126; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] m;
    m = {2'b01, idx, arg};
    return {m, ref_crc({80'b0, m}), 1'b1};
  endfunction

  function automatic logic [135:0] build_rsp(input logic [1:0] rt, input logic [5:0] idx, input attempt_t p);
    logic [135:0] f;
    f = '0;
    for (int k = 0; k < 5; k++) f = {f[103:0], 32'($urandom)};
    if (rt == 2'b10) begin
      f[135:134] = 2'b00;
      f[133:128] = 6'h3F ^ p.idx_xor;
      f[127:8]   = p.data[119:0];
      f[7:1]     = ref_crc(f[127:8]) ^ p.crc_xor;
    end else begin
      f[47:46] = 2'b00;
      f[45:40] = idx ^ p.idx_xor;
      f[39:8]  = p.data[31:0];
      f[7:1]   = ref_crc({80'b0, f[47:8]}) ^ p.crc_xor;
    end
    f[0] = 1'b1;
    return f;
  endfunction

  function automatic bit crc_checked(input logic [1:0] rt);
    return CRC_ON && (rt == 2'b01 || rt == 2'b10);
  endfunction

  task automatic check_val(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick_chk(input string name, input logic [6:0] exp_ctl, input bit chk_frame,
                          input logic [47:0] exp_frame);
    @(posedge clock);
    #1;
    check_val({name, "_ctl"}, 128'({busy, tx_strobe, rx_ack, command_complete, command_timeout,
                                    command_index_error, crc_error}), 128'(exp_ctl));
    check_val({name, "_response"}, response, resp_model);
    if (chk_frame) check_val({name, "_tx_frame"}, 128'(tx_frame), 128'(exp_frame));
  endtask

  // Random activity on inputs the engine must ignore in its current state.
  task automatic noise(input bit in_send);
    new_command   = 1'($urandom);
    cmd_index     = 6'($urandom);
    cmd_argument  = $urandom;
    rsp_type      = 2'($urandom);
    timeout_limit = TO_W'($urandom);
    max_retries   = RETRY_W'($urandom);
    for (int k = 0; k < 5; k++) rx_frame = {rx_frame[103:0], 32'($urandom)};
    rx_strobe = in_send ? 1'($urandom) : 1'b0;
    tx_done   = in_send ? 1'b0 : 1'($urandom);
  endtask

  task automatic set_plan(input int a, input int unsigned hold, input int unsigned delay,
                          input logic [5:0] ix, input logic [6:0] cx, input logic [127:0] data);
    plan[a].hold    = hold;
    plan[a].delay   = delay;
    plan[a].idx_xor = ix;
    plan[a].crc_xor = cx;
    plan[a].data    = data;
  endtask

  // One full command; plan[a] says how the PHY behaves on attempt a.
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input int unsigned lim, input int unsigned maxr);
    logic [47:0]  frame;
    logic [135:0] rf;
    logic [6:0]   exp;
    bit           done;
    frame = ref_frame(idx, arg);
    cmd_index = idx; cmd_argument = arg; rsp_type = rt;
    timeout_limit = TO_W'(lim); max_retries = RETRY_W'(maxr);
    new_command = 1'b1; tx_done = 1'b0; rx_strobe = 1'b0;
    tick_chk("issue", C_SEND, 1'b1, frame);
    done = 1'b0;
    for (int a = 0; a <= int'(maxr) && !done; a++) begin
      for (int h = 0; h < int'(plan[a].hold); h++) begin
        noise(1'b1);
        tick_chk("send_hold", C_SEND, 1'b1, frame);
      end
      noise(1'b1);
      tx_done = 1'b1;
      if (rt == 2'b00) begin
        tick_chk("done_none", C_DONE_NONE, 1'b0, frame);
        done = 1'b1;
      end else begin
        tick_chk("to_wait", C_WAIT, 1'b0, frame);
        if (plan[a].delay <= lim) begin
          for (int d = 0; d < int'(plan[a].delay); d++) begin
            noise(1'b0);
            tick_chk("wait", C_WAIT, 1'b0, frame);
          end
          noise(1'b0);
          rf = build_rsp(rt, idx, plan[a]);
          rx_frame = rf;
          rx_strobe = 1'b1;
          if (rt != 2'b11 && plan[a].idx_xor != 6'd0) begin
            exp = C_IDXERR; done = 1'b1;
          end else if (crc_checked(rt) && plan[a].crc_xor != 7'd0) begin
            if (a < int'(maxr)) exp = C_CRC_RETRY;
            else begin exp = C_CRC_FAIL; done = 1'b1; end
          end else begin
            exp = C_RSP_OK; done = 1'b1;
            resp_model = (rt == 2'b10) ? rf[127:0] : {96'b0, plan[a].data[31:0]};
          end
          tick_chk("response", exp, exp[5], frame);
        end else begin
          for (int d = 0; d < int'(lim); d++) begin
            noise(1'b0);
            tick_chk("wait", C_WAIT, 1'b0, frame);
          end
          noise(1'b0);
          if (a < int'(maxr)) exp = C_SEND;
          else begin exp = C_TIMEOUT; done = 1'b1; end
          tick_chk("limit", exp, exp[5], frame);
        end
      end
    end
    noise(1'b1);
    new_command = 1'b0;
    tx_done = 1'($urandom);
    tick_chk("idle", C_IDLE, 1'b0, frame);
    rx_strobe = 1'b0; tx_done = 1'b0;
  endtask

  initial begin
    tbl[0] = '{6'd0,  32'h0000_0000, 48'h4000_0000_0095};
    tbl[1] = '{6'd8,  32'h0000_01AA, 48'h4800_0001_AA87};
    tbl[2] = '{6'd55, 32'h0000_0000, 48'h7700_0000_0065};
    tbl[3] = '{6'd41, 32'h4000_0000, 48'h6940_0000_0077};
    tbl[4] = '{6'd58, 32'h0000_0000, 48'h7A00_0000_00FD};

    reset = 1'b1; new_command = 1'b0; cmd_index = '0; cmd_argument = '0; rsp_type = '0;
    timeout_limit = '0; max_retries = '0; tx_done = 1'b0; rx_strobe = 1'b0; rx_frame = '0;
    resp_model = '0;
    tick_chk("reset", C_IDLE, 1'b1, 48'h0);
    tick_chk("reset", C_IDLE, 1'b1, 48'h0);
    reset = 1'b0;
    tick_chk("post_reset", C_IDLE, 1'b1, 48'h0);

    // Known-good SD command frames, no response expected.
    for (int i = 0; i < 5; i++) begin
      cmd_index = tbl[i].idx; cmd_argument = tbl[i].arg; rsp_type = 2'b00;
      new_command = 1'b1;
      tick_chk("tbl_issue", C_SEND, 1'b1, tbl[i].frame);
      new_command = 1'b0;
      tick_chk("tbl_hold", C_SEND, 1'b1, tbl[i].frame);
      tx_done = 1'b1;
      tick_chk("tbl_done", C_DONE_NONE, 1'b0, 48'h0);
      tx_done = 1'b0;
      tick_chk("tbl_idle", C_IDLE, 1'b0, 48'h0);
    end

    // CMD17 short response with valid CRC.
    set_plan(0, 2, 2, 6'd0, 7'd0, 128'h0000_0900);
    run_cmd(6'd17, 32'h0000_0200, 2'b01, 5, 0);
    check_val("cmd17_response", response, 128'h0000_0900);

    // No response ever: three attempts then timeout.
    for (int a = 0; a < 3; a++) set_plan(a, a, 99, 6'd0, 7'd0, '0);
    run_cmd(6'd17, 32'h0000_0200, 2'b01, 3, 2);

    // Response carries index 5 instead of 17: no retry, response kept.
    set_plan(0, 1, 0, 6'h14, 7'd0, 128'h1234);
    run_cmd(6'd17, 32'h0000_0200, 2'b01, 4, 2);
    check_val("idxerr_response", response, 128'h0000_0900);

    // Corrupt CRC on attempt 1, good on attempt 2; then corrupt both.
    set_plan(0, 0, 1, 6'd0, 7'h01, 128'hAAAA_5555);
    set_plan(1, 1, 0, 6'd0, 7'd0, 128'hCAFE_F00D);
    run_cmd(6'd17, 32'h0000_0400, 2'b01, 4, 1);
    set_plan(0, 0, 2, 6'd0, 7'h40, 128'h1111);
    set_plan(1, 0, 3, 6'd0, 7'h13, 128'h2222);
    run_cmd(6'd18, 32'h0000_0800, 2'b01, 4, 1);

    // Response exactly on the limit cycle, including limit 0.
    set_plan(0, 0, 3, 6'd0, 7'd0, 128'hBEEF);
    run_cmd(6'd9, 32'h1357_9BDF, 2'b01, 3, 1);
    set_plan(0, 0, 0, 6'd0, 7'd0, 128'h0F0F);
    run_cmd(6'd9, 32'h2468_ACE0, 2'b01, 0, 0);

    // Long response, and R3 with wrong index/CRC bits still accepted.
    set_plan(0, 1, 1, 6'd0, 7'd0, {$urandom, $urandom, $urandom, $urandom});
    run_cmd(6'd2, 32'h0, 2'b10, 4, 0);
    set_plan(0, 0, 1, 6'h2A, 7'h55, 128'h00FF_8000);
    run_cmd(6'd41, 32'h4030_0000, 2'b11, 4, 0);

    // Reset while waiting for a response.
    cmd_index = 6'd13; cmd_argument = 32'h0000_DEAD; rsp_type = 2'b01;
    timeout_limit = TO_W'(10); max_retries = RETRY_W'(1); new_command = 1'b1;
    tick_chk("rst_issue", C_SEND, 1'b1, ref_frame(6'd13, 32'h0000_DEAD));
    new_command = 1'b0; tx_done = 1'b1;
    tick_chk("rst_txdone", C_WAIT, 1'b0, 48'h0);
    tx_done = 1'b0;
    tick_chk("rst_wait", C_WAIT, 1'b0, 48'h0);
    tick_chk("rst_wait", C_WAIT, 1'b0, 48'h0);
    reset = 1'b1; resp_model = '0;
    tick_chk("rst_mid", C_IDLE, 1'b1, 48'h0);
    reset = 1'b0;
    tick_chk("rst_after", C_IDLE, 1'b1, 48'h0);
    set_plan(0, 0, 0, 6'd0, 7'd0, 128'h7777);
    run_cmd(6'd13, 32'h0000_BEEF, 2'b01, 2, 0);

    // Randomized transactions.
    for (int t = 0; t < 80; t++) begin
      int unsigned lim, maxr;
      logic [1:0]  rt;
      lim  = $urandom_range(0, 4);
      maxr = $urandom_range(0, 3);
      rt   = 2'($urandom);
      for (int a = 0; a < 4; a++) begin
        plan[a].hold    = $urandom_range(0, 3);
        plan[a].delay   = $urandom_range(0, lim + 1);
        plan[a].idx_xor = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
        plan[a].crc_xor = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
        plan[a].data    = {$urandom, $urandom, $urandom, $urandom};
      end
      run_cmd(6'($urandom), $urandom, rt, lim, maxr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
